// File: rtl/tw_buf_pkg.sv
// tw_buf_pkg
// Shared helpers for the twiddle buffer generator:
//   - idx_w     : index width for a count (clog2, never narrower than 1 bit)
//   - nseg      : number of write segments in one twiddle word
//   - ident_word: the identity twiddle (value 1 in every segment), built
//                 in a wide container and sliced down by the user
//   - wr_tgt_e  : which storage a write strobe is aimed at
package tw_buf_pkg;

    localparam int MAX_P_WIDTH = 1024;

    typedef enum logic {
        WR_TABLE = 1'b0,
        WR_CONST = 1'b1
    } wr_tgt_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int nseg(input int p_width, input int seg_width);
        return p_width / seg_width;
    endfunction

    function automatic logic [MAX_P_WIDTH-1:0] ident_word(input int p_width, input int seg_width);
        logic [MAX_P_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < p_width / seg_width; i++) begin
            w = w | (MAX_P_WIDTH'(1) << (i * seg_width));
        end
        return w;
    endfunction

endpackage

// File: rtl/tw_seq_cnt.sv
// tw_seq_cnt
// Entry / pass / group counter chain that walks the read sequence.
// Ports:
//   CLK, rst_n  clock and asynchronous active-low reset
//   adv         advance the chain by one read
//   clr         force all counters to 0 at this edge (has priority over adv)
//   grp_lim     effective group count, already limited to 1..GROUPS
//   ent, grp    current entry and group index
//   ent_wrap    entry counter is on its last value
//   pass_wrap   entry and pass counters are both on their last value
module tw_seq_cnt
    import tw_buf_pkg::*;
#(
    parameter int GROUPS  = 4,
    parameter int ENTRIES = 4,
    parameter int REPEAT  = 16
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   adv,
    input  logic                   clr,
    input  logic [idx_w(GROUPS):0] grp_lim,
    output logic [idx_w(ENTRIES)-1:0] ent,
    output logic [idx_w(GROUPS)-1:0]  grp,
    output logic                   ent_wrap,
    output logic                   pass_wrap
);

    localparam int EW  = idx_w(ENTRIES);
    localparam int PW  = idx_w(REPEAT);
    localparam int GW  = idx_w(GROUPS);
    localparam int GNW = GW + 1;

    localparam logic [EW-1:0] ENT_LAST  = EW'(ENTRIES - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(REPEAT - 1);

    logic [EW-1:0]  ent_q,  ent_d;
    logic [PW-1:0]  pass_q, pass_d;
    logic [GW-1:0]  grp_q,  grp_d;
    logic [GNW-1:0] grp_ext;
    logic [GNW-1:0] grp_inc;
    logic           grp_over;

    always_comb begin
        ent_d     = ent_q;
        pass_d    = pass_q;
        grp_d     = grp_q;
        grp_ext   = {1'b0, grp_q};
        grp_inc   = grp_ext + 1'b1;
        // grp_num may have been lowered under the current group; such a group
        // is abandoned on the next advance instead of finishing its passes.
        grp_over  = (grp_ext >= grp_lim);
        ent_wrap  = (ent_q == ENT_LAST);
        pass_wrap = ent_wrap && (pass_q == PASS_LAST);

        if (clr) begin
            ent_d  = '0;
            pass_d = '0;
            grp_d  = '0;
        end else if (adv) begin
            ent_d = ent_wrap ? '0 : ent_q + 1'b1;
            if (ent_wrap) begin
                pass_d = (pass_q == PASS_LAST) ? '0 : pass_q + 1'b1;
            end
            if (grp_over) begin
                grp_d = '0;
            end else if (pass_wrap) begin
                grp_d = (grp_inc >= grp_lim) ? '0 : grp_inc[GW-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ent_q  <= '0;
            pass_q <= '0;
            grp_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            pass_q <= pass_d;
            grp_q  <= grp_d;
        end
    end

    assign ent = ent_q;
    assign grp = grp_q;

endmodule

// File: rtl/tw_buf_gen.sv
// tw_buf_gen
// Twiddle-factor buffer for an NTT datapath. Holds a per-stage table of
// GROUPS x ENTRIES twiddle words plus one constant word per stage, loaded a
// segment at a time, and replays the table for the selected stage.
// Ports:
//   CLK, rst_n                 clock and asynchronous active-low reset
//   stage                      NTT stage selecting the read table and constant
//   rd_en                      advance the read sequence and present a word
//   grp_num                    active group count (0 acts as 1, >GROUPS as GROUPS)
//   wr_en, wr_const            write strobe; wr_const targets the constant word
//   wr_stage/group/entry/seg   write address, segment 0 is the MS segment
//   wr_data                    segment data
//   q, q_valid                 twiddle word (one cycle after rd_en) and qualifier
//   q_const                    registered constant for the current stage
module tw_buf_gen
    import tw_buf_pkg::*;
#(
    parameter int P_WIDTH   = 128,
    parameter int SEG_WIDTH = 64,
    parameter int STAGES    = 3,
    parameter int GROUPS    = 4,
    parameter int ENTRIES   = 4,
    parameter int REPEAT    = 16
) (
    input  logic                                   CLK,
    input  logic                                   rst_n,
    input  logic [idx_w(STAGES)-1:0]               stage,
    input  logic                                   rd_en,
    input  logic [idx_w(GROUPS):0]                 grp_num,
    input  logic                                   wr_en,
    input  logic                                   wr_const,
    input  logic [idx_w(STAGES)-1:0]               wr_stage,
    input  logic [idx_w(GROUPS)-1:0]               wr_group,
    input  logic [idx_w(ENTRIES)-1:0]              wr_entry,
    input  logic [idx_w(nseg(P_WIDTH, SEG_WIDTH))-1:0] wr_seg,
    input  logic [SEG_WIDTH-1:0]                   wr_data,
    output logic [P_WIDTH-1:0]                     q,
    output logic                                   q_valid,
    output logic [P_WIDTH-1:0]                     q_const
);

    localparam int NSEG = nseg(P_WIDTH, SEG_WIDTH);
    localparam int STW  = idx_w(STAGES);
    localparam int GW   = idx_w(GROUPS);
    localparam int EW   = idx_w(ENTRIES);
    localparam int SW   = idx_w(NSEG);
    localparam int GNW  = GW + 1;

    localparam logic [MAX_P_WIDTH-1:0] IDENT_FULL = ident_word(P_WIDTH, SEG_WIDTH);
    localparam logic [P_WIDTH-1:0]     IDENT      = IDENT_FULL[P_WIDTH-1:0];
    localparam logic [P_WIDTH-1:0]     SEG_MASK   = P_WIDTH'({SEG_WIDTH{1'b1}});

    logic [P_WIDTH-1:0] tbl_q [STAGES][GROUPS][ENTRIES];
    logic [P_WIDTH-1:0] tbl_d [STAGES][GROUPS][ENTRIES];
    logic [P_WIDTH-1:0] cst_q [STAGES];
    logic [P_WIDTH-1:0] cst_d [STAGES];
    logic [P_WIDTH-1:0] q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic [P_WIDTH-1:0] q_const_q, q_const_d;
    logic [STW-1:0]     stage_q, stage_d;

    logic               stage_ok;
    logic               stage_chg;
    logic               wr_addr_ok;
    wr_tgt_e            wr_tgt;
    logic [GNW-1:0]     grp_lim;
    logic [EW-1:0]      cnt_ent;
    logic [GW-1:0]      cnt_grp;
    logic               cnt_ent_wrap;
    logic               cnt_pass_wrap;
    logic [STW-1:0]     rd_stg;
    logic [GW-1:0]      rd_grp;
    logic [EW-1:0]      rd_ent;

    // Replace one segment of a word; segment 0 sits in the most significant bits.
    function automatic logic [P_WIDTH-1:0] merge_seg(input logic [P_WIDTH-1:0]   word,
                                                     input logic [SW-1:0]        seg,
                                                     input logic [SEG_WIDTH-1:0] data);
        int sh;
        sh = (NSEG - 1 - int'(seg)) * SEG_WIDTH;
        return (word & ~(SEG_MASK << sh)) | (P_WIDTH'(data) << sh);
    endfunction

    // Address qualification and the effective group count fed to the counters.
    always_comb begin
        stage_ok   = (32'(stage) < STAGES);
        stage_chg  = (stage != stage_q);
        wr_addr_ok = (32'(wr_stage) < STAGES) && (32'(wr_seg) < NSEG);
        wr_tgt     = wr_const ? WR_CONST : WR_TABLE;
        if (grp_num == '0) begin
            grp_lim = GNW'(1);
        end else if (32'(grp_num) > GROUPS) begin
            grp_lim = GNW'(GROUPS);
        end else begin
            grp_lim = grp_num;
        end
    end

    // An out-of-range stage parks the counters at zero; a stage change also
    // restarts them, and the read in that same cycle already uses index 0.
    tw_seq_cnt #(
        .GROUPS  (GROUPS),
        .ENTRIES (ENTRIES),
        .REPEAT  (REPEAT)
    ) u_seq_cnt (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .adv       (rd_en && stage_ok),
        .clr       (stage_chg || !stage_ok),
        .grp_lim   (grp_lim),
        .ent       (cnt_ent),
        .grp       (cnt_grp),
        .ent_wrap  (cnt_ent_wrap),
        .pass_wrap (cnt_pass_wrap)
    );

    // Segment writes into the table or the per-stage constant. The read path
    // samples tbl_q, so a same-cycle write to the word being read is seen only
    // by later reads.
    always_comb begin
        tbl_d = tbl_q;
        cst_d = cst_q;
        if (wr_en && wr_addr_ok) begin
            if (wr_tgt == WR_CONST) begin
                cst_d[wr_stage] = merge_seg(cst_q[wr_stage], wr_seg, wr_data);
            end else if ((32'(wr_group) < GROUPS) && (32'(wr_entry) < ENTRIES)) begin
                tbl_d[wr_stage][wr_group][wr_entry] =
                    merge_seg(tbl_q[wr_stage][wr_group][wr_entry], wr_seg, wr_data);
            end
        end
    end

    // Read word and constant selection for the next output register load.
    always_comb begin
        rd_stg    = stage_ok ? stage : '0;
        rd_grp    = stage_chg ? '0 : cnt_grp;
        rd_ent    = stage_chg ? '0 : cnt_ent;
        stage_d   = stage;
        q_d       = IDENT;
        q_valid_d = rd_en;
        q_const_d = IDENT;
        if (rd_en && stage_ok) begin
            q_d = tbl_q[rd_stg][rd_grp][rd_ent];
        end
        if (stage_ok) begin
            q_const_d = cst_q[rd_stg];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                cst_q[s] <= IDENT;
                for (int g = 0; g < GROUPS; g++) begin
                    for (int e = 0; e < ENTRIES; e++) begin
                        tbl_q[s][g][e] <= IDENT;
                    end
                end
            end
            q_q       <= IDENT;
            q_valid_q <= 1'b0;
            q_const_q <= IDENT;
            stage_q   <= '0;
        end else begin
            tbl_q     <= tbl_d;
            cst_q     <= cst_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_const_q <= q_const_d;
            stage_q   <= stage_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_const = q_const_q;

endmodule

// File: doc/tw_buf_gen.md
TW_BUF_GEN -- requirements
Module: tw_buf_gen

Interface
REQ-001 Parameters: P_WIDTH, default 128, twiddle word width; SEG_WIDTH, default 64, write-segment width, where P_WIDTH = NSEG*SEG_WIDTH; STAGES, default 3, stage count; GROUPS, default 4, maximum groups per stage; ENTRIES, default 4, words per group; REPEAT, default 16, number of passes over one group before the group index advances.
REQ-002 CLK  in  1  clock, all state rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 stage  in  clog2(STAGES)  current NTT stage selecting the read table.
REQ-005 rd_en  in  1  advance the read sequence and drive q this cycle.
REQ-006 grp_num  in  clog2(GROUPS)+1  active group count for the current stage (0 treated as 1; values >GROUPS saturate to GROUPS).
REQ-007 wr_en, wr_const  in  1,1  write strobe, and a flag selecting the constant register instead of the table.
REQ-008 wr_stage, wr_group, wr_entry, wr_seg  in  index widths  write address; wr_seg 0 selects the MS segment.
REQ-009 wr_data  in  SEG_WIDTH  write segment data.
REQ-010 q, q_valid  out  P_WIDTH,1  twiddle word and its qualifier.
REQ-011 q_const  out  P_WIDTH  per-stage constant twiddle.

Function
REQ-012 Storage: table[STAGES][GROUPS][ENTRIES] of P_WIDTH, plus cst[STAGES] of P_WIDTH, all flops.
REQ-013 Write: when wr_en=1, exactly one SEG_WIDTH slice of the addressed word is updated at the next edge; all other bits hold.
REQ-014 An out-of-range write index is ignored without side effects.
REQ-015 Read latency is 1 cycle: q and q_valid register at the edge after rd_en is sampled.
REQ-016 When rd_en=1, q = table[stage][grp][ent] and q_valid=1.
REQ-017 When rd_en=0, q = IDENT and q_valid=0, where IDENT has value 1 in every segment.
REQ-018 Counters: ent 0..ENTRIES-1, pass 0..REPEAT-1, grp 0..grp_num-1; they advance only on edges where rd_en=1.
REQ-019 ent increments every rd_en cycle and wraps to 0 after ENTRIES-1; on the wrap, pass increments.
REQ-020 pass wraps after REPEAT-1; on that wrap, grp increments modulo the effective grp_num.
REQ-021 A stage change (stage differs from its registered copy) zeroes ent, pass and grp at that edge, and the read in that cycle uses index 0,0,0.
REQ-022 If grp_num drops to a value at or below the current grp, grp resets to 0 at the next advance.
REQ-023 If stage >= STAGES: q=IDENT, q_valid=rd_en delayed, and counters hold at 0.
REQ-024 Simultaneous write and read of the same word: q returns pre-write data (read-before-write).
REQ-025 q_const = cst[stage], registered, updated every cycle regardless of rd_en; out-of-range stage gives IDENT.

Reset
REQ-026 On rst_n=0: all table words and cst entries = IDENT; q = IDENT; q_valid=0; q_const=IDENT; counters and the registered stage copy = 0.
REQ-027 Reset assertion mid-sequence takes effect immediately and discards loaded table contents; after release the sequence restarts at 0,0,0.

Structure
REQ-028 Package tw_buf_pkg holds IDENT generation, the NSEG derivation and clog2 index widths.
REQ-029 Sub-module tw_seq_cnt implements the ent/pass/grp counter chain (REQ-018..022) with outputs ent, grp and wrap flags.

Verification
REQ-030 Reset, then rd_en=1 for 4 cycles at stage 0 -> q=IDENT for every word, q_valid rising 1 cycle after rd_en.
REQ-031 Load table[1][g][e] = {g,e} in both segments via 2 writes each (32 writes total), stage=1, grp_num=4, rd_en held 256 cycles -> q cycles e=0..3, group g steps every 64 cycles, wrapping to g=0 after g=3.
REQ-032 Switch stage 1->0 mid-pass (ent=2, pass=5) -> next q = table[0][0][0] and counters restart.
REQ-033 Write seg 1 of table[0][0][0] = 64'hAAAA in the same cycle as reading it -> q = old value, then the following read shows the MS segment unchanged and the LS segment = 64'hAAAA.
REQ-034 grp_num=1 -> grp stays 0 indefinitely; grp_num=0 behaves identically; grp_num=7 behaves as 4.
REQ-035 stage=3 with rd_en=1 -> q=IDENT, q_valid=1 after 1 cycle, q_const=IDENT; wr_stage=3 writes are ignored.
